// File: rtl/spu32_sram16_controller.sv
// Controller for a 16-bit asynchronous SRAM behind a single-cycle-request bus.
// One access runs as IDLE -> ACCESS (WAIT_CYCLES cycles) -> ACK (one cycle).
// A new request seen while in ACK chains straight into the next ACCESS.
// Every output is a flop; the strobe values are derived from the next state.
module spu32_sram16_controller #(
   parameter int SRAM_ADDR_BITS = 18,
   parameter int WAIT_CYCLES    = 2
) (
   input  logic                      I_clk,
   input  logic                      I_reset_n,
   input  logic [3:0]                I_request,
   input  logic [SRAM_ADDR_BITS-1:0] I_addr,
   input  logic [15:0]               I_data,
   input  logic                      I_we,
   input  logic                      I_ub,
   input  logic                      I_lb,
   output logic [15:0]               O_data,
   output logic [3:0]                O_ack,
   output logic                      O_stall,
   output logic [SRAM_ADDR_BITS-1:0] O_sram_addr,
   output logic [15:0]               O_sram_dq,
   output logic                      O_sram_dq_oe,
   input  logic [15:0]               I_sram_dq,
   output logic                      O_sram_ce_n,
   output logic                      O_sram_oe_n,
   output logic                      O_sram_we_n,
   output logic                      O_sram_ub_n,
   output logic                      O_sram_lb_n
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   localparam logic [3:0] LAST_CYCLE = 4'(WAIT_CYCLES - 1);

   logic [1:0]                state, state_nx;
   logic [3:0]                cnt, cnt_nx;
   logic [3:0]                req, req_nx;
   logic                      we, we_nx;
   logic                      ub, ub_nx;
   logic                      lb, lb_nx;
   logic [SRAM_ADDR_BITS-1:0] addr, addr_nx;
   logic [15:0]               data, data_nx;
   logic                      accept;
   logic                      active_nx;
   logic                      en_nx;
   logic                      rd_done;

   // Next-state logic, request acceptance and the values latched at acceptance
   always_comb begin
      accept   = ((state == ST_IDLE) || (state == ST_ACK)) && (I_request != 4'd0);
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_ACCESS;
               cnt_nx   = 4'd0;
            end
         end
         ST_ACCESS: begin
            if (cnt == LAST_CYCLE) begin
               state_nx = ST_ACK;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         ST_ACK: begin
            if (accept) begin
               state_nx = ST_ACCESS;
               cnt_nx   = 4'd0;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      req_nx  = accept ? I_request : req;
      we_nx   = accept ? I_we      : we;
      ub_nx   = accept ? I_ub      : ub;
      lb_nx   = accept ? I_lb      : lb;
      addr_nx = accept ? I_addr    : addr;
      data_nx = accept ? I_data    : data;

      active_nx = (state_nx == ST_ACCESS) || (state_nx == ST_ACK);
      // A request with no byte enabled walks the sequence with the chip deselected
      en_nx     = ub_nx | lb_nx;
      // Read data is captured at the edge that ends the last ACCESS cycle
      rd_done   = (state == ST_ACCESS) && (cnt == LAST_CYCLE) && !we && (ub | lb);
   end

   // Control state and registered outputs; reset drops every strobe immediately
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         req          <= 4'd0;
         we           <= 1'b0;
         ub           <= 1'b0;
         lb           <= 1'b0;
         O_ack        <= 4'd0;
         O_stall      <= 1'b0;
         O_data       <= 16'd0;
         O_sram_addr  <= '0;
         O_sram_dq_oe <= 1'b0;
         O_sram_ce_n  <= 1'b1;
         O_sram_oe_n  <= 1'b1;
         O_sram_we_n  <= 1'b1;
         O_sram_ub_n  <= 1'b1;
         O_sram_lb_n  <= 1'b1;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         req          <= req_nx;
         we           <= we_nx;
         ub           <= ub_nx;
         lb           <= lb_nx;
         O_ack        <= (state_nx == ST_ACK) ? req_nx : 4'd0;
         O_stall      <= (state_nx == ST_ACCESS);
         O_sram_addr  <= addr_nx;
         O_sram_dq_oe <= active_nx && we_nx;
         O_sram_ce_n  <= !(active_nx && en_nx);
         O_sram_ub_n  <= !(active_nx && ub_nx);
         O_sram_lb_n  <= !(active_nx && lb_nx);
         O_sram_oe_n  <= !((state_nx == ST_ACCESS) && !we_nx && en_nx);
         // Cycle 0 is address setup and ACK is data hold, so we_n pulses in between
         O_sram_we_n  <= !((state_nx == ST_ACCESS) && we_nx && en_nx && (cnt_nx != 4'd0));
         if (rd_done) begin
            O_data <= I_sram_dq;
         end
      end
   end

   // Address and write data only follow accepted requests, so they need no reset
   always_ff @(posedge I_clk) begin
      addr      <= addr_nx;
      data      <= data_nx;
      O_sram_dq <= data_nx;
   end

endmodule

// File: tb/tb_spu32_sram16_controller.sv
// Scoreboard bench for spu32_sram16_controller: a driver issues requests and
// pushes the expected response, a monitor checks every ack it sees.
module tb_spu32_sram16_controller;

   localparam int W  = 2;
   localparam int W5 = 5;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] rdata;
      logic [15:0] wdata;
      logic [17:0] addr;
      logic        we;
      logic        ub;
      logic        lb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req = 4'd0;
   logic [17:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        we = 1'b0, ub = 1'b0, lb = 1'b0;
   logic [15:0] rdata, s_dq, s_dq_in;
   logic [3:0]  ack;
   logic        stall, s_dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
   logic [17:0] s_addr;

   logic [3:0]  b_req = 4'd0;
   logic [17:0] b_addr = '0;
   logic        b_ub = 1'b0, b_lb = 1'b0;
   logic [15:0] b_rdata, b_sdq, b_dq_in;
   logic [3:0]  b_ack;
   logic        b_stall, b_sdq_oe, b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;
   logic [17:0] b_saddr;

   logic [15:0] sram_mem [0:511];
   logic [15:0] ref_mem  [0:511];
   logic [15:0] last_rd;
   exp_t        sb[$];
   int          ack_times[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   spu32_sram16_controller #(.SRAM_ADDR_BITS(18), .WAIT_CYCLES(W)) dut (
      .I_clk(clk), .I_reset_n(rst_n), .I_request(req), .I_addr(addr), .I_data(wdata),
      .I_we(we), .I_ub(ub), .I_lb(lb), .O_data(rdata), .O_ack(ack), .O_stall(stall),
      .O_sram_addr(s_addr), .O_sram_dq(s_dq), .O_sram_dq_oe(s_dq_oe), .I_sram_dq(s_dq_in),
      .O_sram_ce_n(ce_n), .O_sram_oe_n(oe_n), .O_sram_we_n(we_n),
      .O_sram_ub_n(ub_n), .O_sram_lb_n(lb_n));

   spu32_sram16_controller #(.SRAM_ADDR_BITS(18), .WAIT_CYCLES(W5)) dut5 (
      .I_clk(clk), .I_reset_n(rst_n), .I_request(b_req), .I_addr(b_addr), .I_data(16'h0000),
      .I_we(1'b0), .I_ub(b_ub), .I_lb(b_lb), .O_data(b_rdata), .O_ack(b_ack), .O_stall(b_stall),
      .O_sram_addr(b_saddr), .O_sram_dq(b_sdq), .O_sram_dq_oe(b_sdq_oe), .I_sram_dq(b_dq_in),
      .O_sram_ce_n(b_ce_n), .O_sram_oe_n(b_oe_n), .O_sram_we_n(b_we_n),
      .O_sram_ub_n(b_ub_n), .O_sram_lb_n(b_lb_n));

   // Asynchronous SRAM models: drive the bus only when selected and output-enabled
   assign s_dq_in = (!ce_n && !oe_n) ? sram_mem[s_addr[8:0]] : 16'hDEAD;
   assign b_dq_in = (!b_ce_n && !b_oe_n) ? (16'h5A00 ^ b_saddr[15:0]) : 16'hDEAD;

   function automatic logic [15:0] init_val(int i);
      logic [31:0] h;
      h = i * 32'h9E3779B1;
      return h[28:13];
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // SRAM array storage: byte-masked write while selected with we_n low
   initial begin
      for (int i = 0; i < 512; i++) sram_mem[i] = init_val(i);
      sram_mem[9'h123] = 16'hBEEF;
      forever begin
         @(posedge clk);
         if (!ce_n && !we_n) begin
            if (!ub_n) sram_mem[s_addr[8:0]][15:8] = s_dq[15:8];
            if (!lb_n) sram_mem[s_addr[8:0]][7:0]  = s_dq[7:0];
         end
      end
   end

   // Monitor: accumulate strobe activity per transaction, check at each ack
   initial begin
      int   cyc, stall_c, ce_c, oe_c, we_c, dqoe_c;
      logic ack_prev;
      exp_t e;
      cyc = 0; stall_c = 0; ce_c = 0; oe_c = 0; we_c = 0; dqoe_c = 0; ack_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            stall_c = 0; ce_c = 0; oe_c = 0; we_c = 0; dqoe_c = 0; ack_prev = 1'b0;
         end else begin
            chk("oe_we_overlap", {31'd0, (!oe_n && !we_n)}, 0);
            stall_c += int'(stall);
            ce_c    += int'(!ce_n);
            oe_c    += int'(!oe_n);
            we_c    += int'(!we_n);
            dqoe_c  += int'(s_dq_oe);
            if (ack != 4'd0) begin
               ack_times.push_back(cyc);
               chk("ack_single_cycle", {31'd0, ack_prev}, 0);
               chk("ack_expected", sb.size(), (sb.size() == 0) ? 1 : sb.size());
               if (sb.size() != 0) begin
                  logic en;
                  e  = sb.pop_front();
                  en = e.ub | e.lb;
                  chk("ack_code", ack, e.code);
                  chk("read_data", rdata, e.rdata);
                  chk("stall_in_ack", stall, 0);
                  chk("stall_cycles", stall_c, W);
                  chk("ce_cycles", ce_c, en ? W + 1 : 0);
                  chk("oe_cycles", oe_c, (!e.we && en) ? W : 0);
                  chk("we_cycles", we_c, (e.we && en) ? W - 1 : 0);
                  chk("dq_oe_cycles", dqoe_c, e.we ? W + 1 : 0);
                  chk("sram_addr", s_addr, e.addr);
                  chk("ub_n", ub_n, !e.ub);
                  chk("lb_n", lb_n, !e.lb);
                  if (e.we) chk("sram_dq", s_dq, e.wdata);
               end
               stall_c = 0; ce_c = 0; oe_c = 0; we_c = 0; dqoe_c = 0;
            end
            ack_prev = (ack != 4'd0);
         end
      end
   end

   // Driver: present a request until the controller takes it, then queue the expectation
   task automatic issue(logic [3:0] c, logic [17:0] a, logic [15:0] d,
                        logic w, logic u, logic l, int gap, bit skip_neg);
      bit   accepted;
      logic st;
      exp_t e;
      if (!skip_neg) @(negedge clk);
      req = c; addr = a; wdata = d; we = w; ub = u; lb = l;
      accepted = 0;
      for (int i = 0; i < 50 && !accepted; i++) begin
         st = stall;
         @(posedge clk);
         if (!st) accepted = 1;
         else @(negedge clk);
      end
      chk("accept_timeout", {31'd0, accepted}, 1);
      e.code = c; e.addr = a; e.wdata = d; e.we = w; e.ub = u; e.lb = l;
      if (!w && (u || l)) last_rd = ref_mem[a[8:0]];
      if (w) begin
         if (u) ref_mem[a[8:0]][15:8] = d[15:8];
         if (l) ref_mem[a[8:0]][7:0]  = d[7:0];
      end
      e.rdata = last_rd;
      sb.push_back(e);
      @(negedge clk);
      req = 4'd0;
      for (int i = 0; i < gap; i++) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_empty", sb.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n0, st5, we5, oe5, ce5, ack5;
      logic [15:0] d5;
      logic [3:0]  c5;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      ref_mem[9'h123] = 16'hBEEF;
      last_rd = 16'd0;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_stall", stall, 0);
      chk("rst_data", rdata, 0);
      chk("rst_ce_n", ce_n, 1);
      chk("rst_oe_n", oe_n, 1);
      chk("rst_we_n", we_n, 1);
      chk("rst_ub_lb_n", {ub_n, lb_n}, 2'b11);
      chk("rst_dq_oe", s_dq_oe, 0);
      chk("rst_addr", s_addr, 0);
      rst_n = 1'b1;

      // Directed read, write of low byte only, read-back
      issue(4'h3, 18'h00123, 16'h0000, 1'b0, 1'b1, 1'b1, 2, 0);
      issue(4'h2, 18'h00123, 16'hA55A, 1'b1, 1'b0, 1'b1, 2, 0);
      drain();
      chk("sram_lb_write", sram_mem[9'h123], 16'hBE5A);
      issue(4'h5, 18'h00123, 16'h0000, 1'b0, 1'b1, 1'b1, 2, 0);
      drain();

      // Back-to-back chain: acks must be exactly one access apart
      n0 = ack_times.size();
      issue(4'hB, 18'h00010, 16'h1111, 1'b1, 1'b1, 1'b1, 0, 0);
      issue(4'hC, 18'h00010, 16'h0000, 1'b0, 1'b1, 1'b1, 0, 0);
      issue(4'h6, 18'h00011, 16'h0000, 1'b0, 1'b1, 1'b1, 0, 0);
      drain();
      chk("b2b_count", ack_times.size() - n0, 3);
      if (ack_times.size() >= n0 + 3) begin
         chk("b2b_gap1", ack_times[n0 + 1] - ack_times[n0], W + 1);
         chk("b2b_gap2", ack_times[n0 + 2] - ack_times[n0 + 1], W + 1);
      end

      // No byte enabled: deselected access, read data must hold
      issue(4'h1, 18'h00020, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0);
      issue(4'h4, 18'h00021, 16'h7777, 1'b1, 1'b0, 1'b0, 1, 0);
      drain();

      // Randomized mix of reads, writes, byte enables and gaps
      for (int t = 0; t < 60; t++) begin
         issue(4'($urandom_range(1, 15)), 18'($urandom_range(0, 63)), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 0);
      end
      drain();

      // Reset in ACCESS cycle 1 of a write aborts it without an ack
      @(negedge clk);
      req = 4'h7; addr = 18'h001FF; wdata = 16'h1234; we = 1'b1; ub = 1'b1; lb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req = 4'd0;
      @(posedge clk);
      #2;
      chk("abort_we_low", we_n, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_we_n", we_n, 1);
      chk("abort_ce_n", ce_n, 1);
      chk("abort_dq_oe", s_dq_oe, 0);
      chk("abort_stall", stall, 0);
      chk("abort_ack", ack, 0);
      chk("abort_data", rdata, 0);
      last_rd = 16'd0;
      n0 = ack_times.size();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_ack", ack_times.size() - n0, 0);
      chk("abort_no_write", sram_mem[9'h1FF], init_val(511));

      // Acceptance on the first edge after release
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      fork
         issue(4'h9, 18'h00123, 16'h0000, 1'b0, 1'b1, 1'b1, 1, 1);
         begin
            @(posedge clk);
            #1 chk("first_accept_stall", stall, 1);
         end
      join
      drain();

      // WAIT_CYCLES=5 instance: one read with per-cycle strobe accounting
      @(negedge clk);
      b_req = 4'hA; b_addr = 18'h00042; b_ub = 1'b1; b_lb = 1'b1;
      @(posedge clk);
      #1 b_req = 4'd0;
      st5 = 0; we5 = 0; oe5 = 0; ce5 = 0; ack5 = 0; d5 = 16'd0; c5 = 4'd0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         st5 += int'(b_stall);
         we5 += int'(!b_we_n);
         oe5 += int'(!b_oe_n);
         ce5 += int'(!b_ce_n);
         chk("w5_dq_oe", b_sdq_oe, 0);
         if (b_ack != 4'd0) begin
            ack5++;
            c5 = b_ack;
            d5 = b_rdata;
            chk("w5_ub_lb_n", {b_ub_n, b_lb_n}, 2'b00);
         end
      end
      chk("w5_stall_cycles", st5, W5);
      chk("w5_we_cycles", we5, 0);
      chk("w5_oe_cycles", oe5, W5);
      chk("w5_ce_cycles", ce5, W5 + 1);
      chk("w5_ack_cycles", ack5, 1);
      chk("w5_ack_code", c5, 4'hA);
      chk("w5_read_data", d5, 16'h5A42);
      chk("w5_data_held", b_rdata, 16'h5A42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
